// File: rtl/spi_slave_driver_if.sv
// Pin-side and buffer-side signals of the SPI slave front end.
// The slave modport is the driver's view; the master modport is the pins plus buffers.
interface spi_slave_driver_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  sclk;
  logic                  cs;
  logic                  mosi;
  logic                  miso;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid;
  logic                  start;
  logic                  stop;

  modport slave (
    input  sclk, cs, mosi, data_in,
    output miso, ready, data_out, valid, start, stop
  );

  modport master (
    output sclk, cs, mosi, data_in,
    input  miso, ready, data_out, valid, start, stop
  );
endinterface

// File: rtl/spi_slave_driver.sv
// SPI mode-0 slave front end: pin synchronizers, MSB-first rx deserializer,
// tx serializer fed from the send buffer, transaction start/stop pulses.
//
// state | meaning
// IDLE  | cs deasserted (or not yet armed); miso held at 0
// SHIFT | transaction open; sample mosi on sclk rise, advance miso on sclk fall
module spi_slave_driver #(
  parameter int DATA_WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  spi_slave_driver_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic sclk_s1, sclk_s2, sclk_d;
  logic cs_s1, cs_s2, cs_d;
  logic mosi_s1, mosi_s2;
  logic [1:0] flush;
  logic armed;

  logic [0:0]            state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic [DATA_WIDTH-1:0] rx_next;
  logic [DATA_WIDTH-1:0] data_out_r;
  logic                  valid_r;
  logic                  load_pending;

  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic txn_begin, txn_end, rx_tick, tx_tick;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_d  <= 1'b0;
      cs_s1   <= 1'b1;
      cs_s2   <= 1'b1;
      cs_d    <= 1'b1;
      mosi_s1 <= 1'b0;
      mosi_s2 <= 1'b0;
    end else begin
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_d  <= sclk_s2;
      cs_s1   <= bus.cs;
      cs_s2   <= cs_s1;
      cs_d    <= cs_s2;
      mosi_s1 <= bus.mosi;
      mosi_s2 <= mosi_s1;
    end
  end

  // The cs chain resets to 1, so its first two outputs after reset are not
  // real pin samples; arming waits until the chain has been flushed.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush <= 2'b00;
      armed <= 1'b0;
    end else begin
      flush <= {flush[0], 1'b1};
      if (flush[1] && cs_s2)
        armed <= 1'b1;
    end
  end

  assign sclk_rise = sclk_s2 & ~sclk_d;
  assign sclk_fall = ~sclk_s2 & sclk_d;
  assign cs_rise   = cs_s2 & ~cs_d;
  assign cs_fall   = ~cs_s2 & cs_d;

  // cs rise takes priority over any sclk edge detected in the same cycle.
  assign txn_begin = (state == IDLE) && cs_fall && armed;
  assign txn_end   = (state == SHIFT) && cs_rise;
  assign rx_tick   = (state == SHIFT) && !cs_rise && sclk_rise;
  assign tx_tick   = (state == SHIFT) && !cs_rise && sclk_fall;

  assign rx_next = {rx_shift[DATA_WIDTH-2:0], mosi_s2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      tx_shift     <= '0;
      rx_shift     <= '0;
      data_out_r   <= '0;
      valid_r      <= 1'b0;
      load_pending <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        IDLE: begin
          if (txn_begin) begin
            state        <= SHIFT;
            tx_shift     <= bus.data_in;
            bit_cnt      <= '0;
            rx_shift     <= '0;
            load_pending <= 1'b0;
          end
        end
        SHIFT: begin
          if (txn_end) begin
            state        <= IDLE;
            bit_cnt      <= '0;
            load_pending <= 1'b0;
          end else if (rx_tick) begin
            rx_shift <= rx_next;
            if (bit_cnt == LAST_BIT) begin
              data_out_r   <= rx_next;
              valid_r      <= 1'b1;
              bit_cnt      <= '0;
              load_pending <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + CNT_W'(1);
            end
          end else if (tx_tick) begin
            if (load_pending) begin
              tx_shift     <= bus.data_in;
              load_pending <= 1'b0;
            end else begin
              tx_shift <= tx_shift << 1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.start    = txn_begin;
  assign bus.stop     = txn_end;
  assign bus.ready    = txn_begin | (tx_tick & load_pending);
  assign bus.miso     = (state == SHIFT) & tx_shift[DATA_WIDTH-1];
  assign bus.data_out = data_out_r;
  assign bus.valid    = valid_r;

endmodule

// File: tb/tb_spi_slave_driver.sv
// Bench for spi_slave_driver: an SPI master and send-buffer model drive the pins,
// expected words/pulse counts come from transaction-level rules.
module tb_spi_slave_driver;

  localparam int W = 8;

  logic clk;
  logic rst;
  logic [7:0] mem [256];
  logic [7:0] ptr;
  logic pend_adv;

  spi_slave_driver_if #(.DATA_WIDTH(W)) bus ();

  spi_slave_driver #(.DATA_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  assign bus.data_in = mem[ptr];

  int vectors;
  int fails;
  int ready_cnt, valid_cnt, start_cnt, stop_cnt;
  int exp_rdy;
  int cs_hi_cyc;
  logic [7:0] exp_last;
  logic [7:0] prev_dout;
  logic [7:0] exp_rx [$];
  logic [7:0] mosi_w [4];
  logic [7:0] rxw [4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Send buffer: advances one negedge after the cycle in which ready was seen.
  initial begin
    ptr = 8'd0;
    pend_adv = 1'b0;
  end
  always @(negedge clk) begin
    if (pend_adv) ptr = ptr + 8'd1;
    pend_adv = (bus.ready === 1'b1);
  end

  // Per-cycle compare process.
  always @(negedge clk) begin
    if (!rst) begin
      check("reset_outputs",
            {24'd0, bus.ready, bus.valid, bus.start, bus.stop, bus.miso, 3'd0} |
            {24'd0, bus.data_out}, 32'd0);
      prev_dout = 8'd0;
    end else begin
      if (bus.ready) ready_cnt++;
      if (bus.start) start_cnt++;
      if (bus.stop)  stop_cnt++;
      if (bus.start) check("start_with_ready", bus.ready, 1);
      if (bus.valid) begin
        valid_cnt++;
        if (exp_rx.size() == 0)
          check("valid_unexpected", 1, 0);
        else
          check("valid_data", bus.data_out, exp_rx.pop_front());
      end
      if (bus.data_out != prev_dout) check("dout_change_with_valid", bus.valid, 1);
      prev_dout = bus.data_out;
      if (cs_hi_cyc >= 4) check("idle_miso", bus.miso, 0);
    end
    if (bus.cs) cs_hi_cyc++;
    else cs_hi_cyc = 0;
  end

  // end_mode: 0 sclk low then cs rise, 1 cs rise with last sclk fall,
  //           2 cs rise with last sclk rise, 3 leave cs low (caller ends it).
  task automatic xfer(input int nbits, input int half, input int end_mode);
    int complete, prefetch, base, r0, v0, s0, t0;
    base = exp_rdy;
    r0 = ready_cnt; v0 = valid_cnt; s0 = start_cnt; t0 = stop_cnt;
    complete = (end_mode == 2) ? (nbits - 1) / W : nbits / W;
    for (int k = 0; k < complete; k++) exp_rx.push_back(mosi_w[k]);
    for (int k = 0; k < 4; k++) rxw[k] = 8'h00;
    bus.cs = 1'b0;
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      bus.mosi = mosi_w[b / W][W - 1 - (b % W)];
      repeat (half) @(negedge clk);
      bus.sclk = 1'b1;
      if (b == nbits - 1 && end_mode == 2) bus.cs = 1'b1;
      rxw[b / W] = {rxw[b / W][W-2:0], bus.miso};
      repeat (half) @(negedge clk);
      bus.sclk = 1'b0;
      if (b == nbits - 1 && end_mode == 1) bus.cs = 1'b1;
    end
    if (end_mode == 0) begin
      repeat (half) @(negedge clk);
      bus.cs = 1'b1;
    end
    if (end_mode != 3) begin
      repeat (8) @(negedge clk);
      prefetch = (end_mode == 1) ? complete - 1 : complete;
      check("start_count", start_cnt - s0, 1);
      check("stop_count", stop_cnt - t0, 1);
      check("valid_count", valid_cnt - v0, complete);
      check("ready_count", ready_cnt - r0, 1 + prefetch);
      for (int k = 0; k < complete; k++) begin
        check("miso_word", rxw[k], mem[8'(base + k)]);
        exp_last = mosi_w[k];
      end
      check("dout_hold", bus.data_out, exp_last);
      check("rx_queue_empty", exp_rx.size(), 0);
      exp_rdy = exp_rdy + 1 + prefetch;
    end else begin
      exp_rdy = exp_rdy + 1;
    end
  endtask

  initial begin
    int s_before, nw, half;
    vectors = 0; fails = 0;
    ready_cnt = 0; valid_cnt = 0; start_cnt = 0; stop_cnt = 0;
    exp_rdy = 0; cs_hi_cyc = 0; exp_last = 8'h00; prev_dout = 8'h00;
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b0;
    bus.cs = 1'b1; bus.sclk = 1'b0; bus.mosi = 1'b0;
    repeat (4) @(negedge clk);
    check("rst_data_out", bus.data_out, 0);
    check("rst_miso", bus.miso, 0);
    rst = 1'b1;
    repeat (8) @(negedge clk);

    // single byte, cs released together with the final sclk fall
    mosi_w[0] = 8'hA5; mem[exp_rdy] = 8'h3C;
    xfer(8, 4, 1);
    check("single_data_out", bus.data_out, 32'hA5);
    check("single_miso", rxw[0], 32'h3C);
    check("single_ready_total", ready_cnt, 1);
    check("single_valid_total", valid_cnt, 1);

    // abort after 5 bits keeps the previous word
    mosi_w[0] = 8'hFF;
    xfer(5, 4, 0);
    check("abort_data_out", bus.data_out, 32'hA5);
    check("abort_valid_total", valid_cnt, 1);

    mosi_w[0] = 8'h5A;
    xfer(8, 8, 0);
    check("after_abort_data_out", bus.data_out, 32'h5A);

    // three bytes in one window
    mosi_w[0] = 8'h01; mosi_w[1] = 8'h02; mosi_w[2] = 8'h03;
    mem[8'(exp_rdy)] = 8'h11; mem[8'(exp_rdy + 1)] = 8'h22; mem[8'(exp_rdy + 2)] = 8'h33;
    xfer(24, 4, 0);
    check("three_miso0", rxw[0], 32'h11);
    check("three_miso1", rxw[1], 32'h22);
    check("three_miso2", rxw[2], 32'h33);
    check("three_ready_total", ready_cnt, 8);
    check("three_valid_total", valid_cnt, 5);

    // cs rise in the same detect cycle as the 8th sclk rise
    mosi_w[0] = 8'hC3;
    xfer(8, 4, 2);
    check("collide_data_out", bus.data_out, 32'h03);

    // reset mid-word with cs held low
    mosi_w[0] = 8'h96;
    xfer(4, 4, 3);
    #2 rst = 1'b0;
    #1;
    check("midrst_ready", bus.ready, 0);
    check("midrst_valid", bus.valid, 0);
    check("midrst_start", bus.start, 0);
    check("midrst_stop", bus.stop, 0);
    check("midrst_miso", bus.miso, 0);
    check("midrst_data_out", bus.data_out, 0);
    exp_last = 8'h00;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    s_before = start_cnt;
    repeat (20) @(negedge clk);
    check("no_start_while_cs_low", start_cnt, s_before);
    bus.cs = 1'b1;
    repeat (8) @(negedge clk);
    mosi_w[0] = 8'h6E;
    xfer(8, 4, 0);
    check("post_reset_data_out", bus.data_out, 32'h6E);

    // randomized sweep at clk/8 and clk/16
    for (int t = 0; t < 16; t++) begin
      nw = int'($urandom_range(1, 3));
      half = ($urandom_range(0, 1) == 1) ? 4 : 8;
      for (int k = 0; k < 4; k++) mosi_w[k] = 8'($urandom);
      xfer(nw * W, half, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
